icache_dm: RTL

//  Direct-mapped, read-only instruction cache between the IF stage (SRAM-like req/addr_ok/data_ok) and the
//  AXI bridge icache rd interface. Hits return one cycle after acceptance. Misses issue one 4-word line

---
 rtl/icache_dm_pkg.sv | 20 ++
 rtl/icache_dm_line_store.sv | 55 +++++
 rtl/icache_dm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/icache_dm_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
//   RdTypeLine : bridge read type for a full 4-word line
//   OffsetW    : byte-offset bits within a line
//   LineWords  : 32-bit words per line
//   state_e    : one-hot controller states
package icache_dm_pkg;

  localparam logic [2:0]  RdTypeLine = 3'b100;
  localparam int unsigned OffsetW    = 4;
  localparam int unsigned LineWords  = 4;

  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StLookup = 5'b00010,
    StMiss   = 5'b00100,
    StRefill = 5'b01000,
    StResp   = 5'b10000
  } state_e;

endpackage

// File: rtl/icache_dm_line_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst_n            : clock; async active-low reset (clears valid bits only)
//   rd_index, rd_word     : combinational read port (set and word select)
//   rd_valid, rd_tag      : valid bit and tag of the addressed set
//   rd_data               : selected word of the addressed set
//   wr_en/index/word/data : per-beat refill word write
//   commit_en/index/tag   : marks a refilled line valid with its tag
module icache_dm_line_store
  import icache_dm_pkg::*;
#(
  parameter int unsigned IndexW = 6,
  parameter int unsigned TagW   = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IndexW-1:0] rd_index,
  input  logic [1:0]        rd_word,
  output logic              rd_valid,
  output logic [TagW-1:0]   rd_tag,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [IndexW-1:0] wr_index,
  input  logic [1:0]        wr_word,
  input  logic [31:0]       wr_data,
  input  logic              commit_en,
  input  logic [IndexW-1:0] commit_index,
  input  logic [TagW-1:0]   commit_tag
);

  localparam int unsigned Sets = 1 << IndexW;

  logic [Sets-1:0] valid_q;
  logic [TagW-1:0] tag_q  [Sets];
  logic [31:0]     data_q [Sets][LineWords];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (commit_en) begin
      valid_q[commit_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: a set is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (commit_en) tag_q[commit_index] <= commit_tag;
    if (wr_en)     data_q[wr_index][wr_word] <= wr_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache between the IF stage and the AXI bridge.
// Hits return data one cycle after acceptance; misses fetch a 4-word line and return
// the requested word one cycle after the last refill beat.
// Ports:
//   aclk, aresetn           : clock; async active-low reset
//   valid, addr, addr_ok    : fetch request handshake
//   cancel                  : suppress data_ok of the outstanding fetch
//   data_ok, rdata          : fetch response
//   rd_req/type/addr/rdy    : line read request to bridge
//   ret_valid/last/data     : refill beats from bridge
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cancel,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              rd_req,
  output logic [2:0]        rd_type,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic              ret_last,
  input  logic [31:0]       ret_data
);

  localparam int unsigned TagW = ADDR_W - INDEX_W - OffsetW;

  state_e              state_q, state_d;
  logic [ADDR_W-1:2]   req_addr_q;
  logic [1:0]          beat_q;
  logic                cancelled_q;
  logic [31:0]         rdata_q;

  logic [INDEX_W-1:0]  req_index;
  logic [TagW-1:0]     req_tag;
  logic                line_valid;
  logic [TagW-1:0]     line_tag;
  logic [31:0]         line_word;
  logic                hit;
  logic                beat_wr;
  logic                unused_addr;

  assign unused_addr = ^addr[1:0];

  assign req_index = req_addr_q[INDEX_W+OffsetW-1:OffsetW];
  assign req_tag   = req_addr_q[ADDR_W-1:INDEX_W+OffsetW];
  assign hit       = (state_q == StLookup) && line_valid && (line_tag == req_tag);
  assign beat_wr   = (state_q == StRefill) && ret_valid;

  icache_dm_line_store #(
    .IndexW (INDEX_W),
    .TagW   (TagW)
  ) u_line_store (
    .clk          (aclk),
    .rst_n        (aresetn),
    .rd_index     (req_index),
    .rd_word      (req_addr_q[3:2]),
    .rd_valid     (line_valid),
    .rd_tag       (line_tag),
    .rd_data      (line_word),
    .wr_en        (beat_wr),
    .wr_index     (req_index),
    .wr_word      (beat_q),
    .wr_data      (ret_data),
    .commit_en    (beat_wr && ret_last),
    .commit_index (req_index),
    .commit_tag   (req_tag)
  );

  always_comb begin
    state_d = state_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rd_req  = 1'b0;
    unique case (state_q)
      StIdle: begin
        addr_ok = 1'b1;
        if (valid) state_d = StLookup;
      end
      StLookup: begin
        if (hit) begin
          addr_ok = ~cancel;
          data_ok = ~cancel;
          state_d = (valid && !cancel) ? StLookup : StIdle;
        end else begin
          state_d = cancel ? StIdle : StMiss;
        end
      end
      StMiss: begin
        rd_req = 1'b1;
        if (rd_rdy) state_d = StRefill;
      end
      StRefill: begin
        if (ret_valid && ret_last) state_d = StResp;
      end
      StResp: begin
        data_ok = ~cancelled_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      beat_q      <= '0;
      cancelled_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (valid && addr_ok) req_addr_q <= addr[ADDR_W-1:2];
      if (state_q == StMiss && rd_rdy) begin
        beat_q <= '0;
      end else if (beat_wr) begin
        beat_q <= beat_q + 2'd1;
      end
      // Capture only the requested word; the response is never forwarded early.
      if (beat_wr && beat_q == req_addr_q[3:2]) rdata_q <= ret_data;
      if ((state_q == StMiss || state_q == StRefill) && cancel) begin
        cancelled_q <= 1'b1;
      end else if (state_q == StResp) begin
        cancelled_q <= 1'b0;
      end
    end
  end

  assign rdata   = hit ? line_word : rdata_q;
  assign rd_type = RdTypeLine;
  assign rd_addr = {req_addr_q[ADDR_W-1:OffsetW], {OffsetW{1'b0}}};

endmodule
